// File: rtl/fifo_cas_pkg.sv
// Shared constants and types for the cascaded synchronous FIFO.
// Capacity/count-width helpers and the overflow/underflow status bundle.
package fifo_cas_pkg;

  function automatic int cas_capacity(input int ns, input int sd);
    return ns * sd;
  endfunction

  function automatic int cas_cnt_w(input int cap);
    return $clog2(cap + 1);
  endfunction

  typedef struct packed {
    logic ovf;
    logic udf;
  } cas_err_t;

  localparam cas_err_t ERR_NONE = '{ovf: 1'b0, udf: 1'b0};

endpackage

// File: rtl/fifo_cas_stage.sv
// One cascade stage: single-clock FIFO, combinational head read.
// Ports: clk_i, rst_i, push_i/din_i, pop_i/head_o, full_o, empty_o, occ_o.
module fifo_cas_stage
  import fifo_cas_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     occ_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // occupancy tops out at DEPTH, a power of two, so the MSB alone means full
  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = occ_q[AW];
  assign empty_o = (occ_q == '0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_cas_sync.sv
// Cascaded sync FIFO: NUM_STAGES stage FIFOs chained, global count/flags.
// Ports: clk, rst, wr_en/din, rd_en/dout/valid, full/almost_full,
// empty/almost_empty, count, overflow/underflow. Macro FIFO_CAS_FWFT_EN
// selects first-word fall-through; undefined gives registered-read mode.
module fifo_cas_sync
  import fifo_cas_pkg::*;
#(
  parameter int WIDTH         = 36,
  parameter int STAGE_DEPTH   = 512,
  parameter int NUM_STAGES    = 2,
  parameter int AFULL_THRESH  = NUM_STAGES * STAGE_DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         wr_en,
  input  logic [WIDTH-1:0]                             din,
  input  logic                                         rd_en,
  output logic [WIDTH-1:0]                             dout,
  output logic                                         valid,
  output logic                                         full,
  output logic                                         almost_full,
  output logic                                         empty,
  output logic                                         almost_empty,
  output logic [$clog2(NUM_STAGES*STAGE_DEPTH+1)-1:0]  count,
  output logic                                         overflow,
  output logic                                         underflow
);

  localparam int CAPACITY = cas_capacity(NUM_STAGES, STAGE_DEPTH);
  localparam int CNT_W    = cas_cnt_w(CAPACITY);
  localparam int OCC_W    = $clog2(STAGE_DEPTH) + 1;
  localparam int LAST     = NUM_STAGES - 1;

  localparam logic [CNT_W-1:0] AF_T = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AE_T = CNT_W'(AEMPTY_THRESH);

  logic [WIDTH-1:0]      head [NUM_STAGES];
  logic [NUM_STAGES-1:0] s_full, s_empty;
  logic [NUM_STAGES-1:0] push, pop;
  logic                  wr_acc, rd_acc;

  logic [CNT_W-1:0] count_q, count_d;
  logic             af_q, ae_q;
  cas_err_t         err_q;

  assign wr_acc = wr_en & ~s_full[0] & ~rst;
  assign rd_acc = rd_en & ~s_empty[LAST] & ~rst;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] s_din;
    logic [OCC_W-1:0] occ;
    logic             unused_occ;

    if (k == 0) begin : g_first
      assign push[k] = wr_acc;
      assign s_din   = din;
    end else begin : g_next
      assign push[k] = pop[k-1];
      assign s_din   = head[k-1];
    end

    // every boundary moves a word whenever it can, all in parallel
    if (k == LAST) begin : g_last
      assign pop[k] = rd_acc;
    end else begin : g_inner
      assign pop[k] = ~s_empty[k] & ~s_full[k+1];
    end

    fifo_cas_stage #(
      .WIDTH (WIDTH),
      .DEPTH (STAGE_DEPTH)
    ) u_stage (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push[k]),
      .din_i   (s_din),
      .pop_i   (pop[k]),
      .head_o  (head[k]),
      .full_o  (s_full[k]),
      .empty_o (s_empty[k]),
      .occ_o   (occ)
    );

    assign unused_occ = ^occ;
  end

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      err_q   <= ERR_NONE;
    end else begin
      count_q   <= count_d;
      af_q      <= (count_d >= AF_T);
      ae_q      <= (count_d <= AE_T);
      err_q.ovf <= wr_en & s_full[0];
      err_q.udf <= rd_en & s_empty[LAST];
    end
  end

  assign full         = s_full[0];
  assign empty        = s_empty[LAST];
  assign count        = count_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = err_q.ovf;
  assign underflow    = err_q.udf;

`ifdef FIFO_CAS_FWFT_EN
  // the head of an empty stage is stale memory, so mask it
  assign dout  = s_empty[LAST] ? '0 : head[LAST];
  assign valid = ~s_empty[LAST];
`else
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_acc;
      if (rd_acc) dout_q <= head[LAST];
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
`endif

endmodule

// File: doc/fifo_cas_sync.md
FIFO_CAS_SYNC -- requirements
Module: fifo_cas_sync

Interface
REQ-001 Parameter WIDTH, default 36: data word width in bits.
REQ-002 Parameter STAGE_DEPTH, default 512: words per cascade stage; power of two, at least 2.
REQ-003 Parameter NUM_STAGES, default 2: number of cascaded stages, 1..8.
REQ-004 Parameter AFULL_THRESH, default CAPACITY-4: almost_full threshold, where CAPACITY = NUM_STAGES*STAGE_DEPTH.
REQ-005 Parameter AEMPTY_THRESH, default 4: almost_empty threshold.
REQ-006 clk  in  1: single clock; all logic on the rising edge.
REQ-007 rst  in  1: reset, synchronous, active-high.
REQ-008 wr_en  in  1: write request.
REQ-009 din  in  WIDTH: write data.
REQ-010 rd_en  in  1: read request (pop).
REQ-011 dout  out  WIDTH: read data.
REQ-012 valid  out  1: dout holds a valid word.
REQ-013 full / almost_full  out  1 each: writer-side status.
REQ-014 empty / almost_empty  out  1 each: reader-side status.
REQ-015 count  out  $clog2(CAPACITY+1): total words held across all stages.
REQ-016 overflow / underflow  out  1 each: single-cycle error pulses.

Function
REQ-017 A write is accepted at an edge when wr_en=1 and full=0; din enters stage 0.
REQ-018 At every edge, stage k (k < NUM_STAGES-1) transfers one word to stage k+1 when stage k is non-empty and stage k+1 is not full; all boundaries transfer concurrently.
REQ-019 A word accepted at edge t reaches the last stage after edge t+NUM_STAGES-1 when downstream is empty.
REQ-020 full = stage 0 full; empty = last stage empty.
REQ-021 Order is strictly preserved end to end; no word is lost or duplicated.
REQ-022 count increments on an accepted write and decrements on an accepted read; it is unchanged when both are accepted in the same cycle; inter-stage transfers never change it.
REQ-023 almost_full = (count >= AFULL_THRESH); almost_empty = (count <= AEMPTY_THRESH); both registered with count.
REQ-024 wr_en=1 while full=1: write ignored; overflow=1 for the next cycle; contents unchanged.
REQ-025 rd_en=1 while empty=1: read ignored; underflow=1 for the next cycle; dout held.
REQ-026 Simultaneous write and read: each is judged independently against the current full and empty flags.
REQ-027 Stage pointers wrap modulo STAGE_DEPTH; per-stage occupancy uses one extra bit to distinguish full from empty.

Reset
REQ-028 While rst=1, all contents are discarded and wr_en and rd_en are ignored, with no overflow or underflow pulses.
REQ-029 Reset values: empty=1, almost_empty=1, full=0, almost_full=0, count=0, dout=0, valid=0, overflow=0, underflow=0.
REQ-030 Reset mid-operation takes effect at the next edge regardless of occupancy or in-flight transfers.

Configuration
REQ-031 Macro FIFO_CAS_FWFT_EN defined (first-word fall-through): dout shows the head word and valid = !empty; rd_en=1 with empty=0 pops the head at that edge.
REQ-032 Macro FIFO_CAS_FWFT_EN undefined (standard mode): rd_en=1 with empty=0 at edge r loads the head word into dout after edge r; valid=1 for exactly that cycle and 0 otherwise.

Structure
REQ-033 Package fifo_cas_pkg holds the CAPACITY and count-width constants and the overflow/underflow status encoding.
REQ-034 Sub-module fifo_cas_stage (a single-clock FIFO with combinational head read, full, empty and occupancy) is instantiated NUM_STAGES times in a generate loop.

Verification (WIDTH=36, STAGE_DEPTH=16, NUM_STAGES=2, AFULL_THRESH=28, AEMPTY_THRESH=4)
REQ-035 rst=1 for 5 cycles with wr_en=1 and din=36'h1 -> after reset, empty=1, count=0, overflow=0.
REQ-036 Single write of 36'h1 into an empty FIFO at edge t -> empty=0 after edge t+1; rd_en then gives dout=36'h1 (valid=1 one cycle in standard mode).
REQ-037 40 back-to-back writes of 1..40 with rd_en=0 -> 32 words accepted, count=32, full=1, almost_full=1 from count=28, 8 overflow pulses.
REQ-038 Drain after REQ-037 with 33 reads -> dout=1..32 in order, empty=1 after the 32nd read, almost_empty=1 from count=4, one underflow pulse.
REQ-039 Continuous simultaneous read and write at count=10 for 50 cycles -> count stays 10 and output order is preserved.
REQ-040 rst pulse at count=10 -> count=0 and empty=1 next cycle; then writing 36'hA reads back 36'hA.
